// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the two-master AHB arbiter.
package ahb_arb_pkg;

  // Width of the tenure counter; MAX_TENURE must fit in it.
  localparam int TEN_W = 8;

  // hmaster / hmaster_data encodings (one-hot per master).
  localparam logic [1:0] HM_M1 = 2'b01;
  localparam logic [1:0] HM_M2 = 2'b10;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_GRANT1 = 2'd1,
    ST_GRANT2 = 2'd2
  } arb_state_e;

  // Address-phase owner implied by an arbiter state.
  function automatic logic [1:0] state_hm(arb_state_e s, logic [1:0] park_hm);
    logic [1:0] hm;
    case (s)
      ST_GRANT1: hm = HM_M1;
      ST_GRANT2: hm = HM_M2;
      default:   hm = park_hm;
    endcase
    return hm;
  endfunction

endpackage

// File: rtl/ahb_tenure_cnt.sv
// Saturating count of active address-phase beats held by the current owner.
module ahb_tenure_cnt
  import ahb_arb_pkg::*;
#(
  parameter int MAX_TENURE = 16
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             inc,
  input  logic             clr,
  output logic [TEN_W-1:0] count,
  output logic             at_max
);

  localparam logic [TEN_W-1:0] MAX_CNT = TEN_W'(MAX_TENURE);

  logic [TEN_W-1:0] count_q;
  logic [TEN_W-1:0] count_d;

  // Clear wins over increment; the count sticks once it reaches the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_CNT);

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB bus arbiter with parking, round-robin tie break and
// a tenure limit that forces the owner to yield to a waiting master.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_TENURE  = 16,
  parameter int PARK_MASTER = 1
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hbusreq1,
  input  logic       hbusreq2,
  input  logic       htrans,
  input  logic       hready,
  output logic       hgrant1,
  output logic       hgrant2,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_data
);

  localparam logic [1:0] PARK_HM = (PARK_MASTER == 2) ? HM_M2 : HM_M1;

  arb_state_e       state_q, state_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic [1:0]       hmaster_q, hmaster_d;
  logic [1:0]       hmaster_data_q;
  logic             hgrant1_q, hgrant2_q;

  logic [TEN_W-1:0] tenure_cnt;
  logic             tenure_at_max;
  logic             tenure_inc;
  logic             tenure_clr;
  logic             state_change;

  // Next-state arbitration; nothing moves unless the current transfer completes.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    if (hready) begin
      case (state_q)
        ST_PARK: begin
          if (hbusreq1 && hbusreq2) begin
            state_d = (last_owner_q == HM_M1) ? ST_GRANT2 : ST_GRANT1;
          end else if (hbusreq1) begin
            state_d = ST_GRANT1;
          end else if (hbusreq2) begin
            state_d = ST_GRANT2;
          end
        end
        ST_GRANT1: begin
          if (!hbusreq1 || (tenure_at_max && hbusreq2)) begin
            if (hbusreq2)      state_d = ST_GRANT2;
            else if (hbusreq1) state_d = ST_GRANT1;
            else               state_d = ST_PARK;
          end
        end
        ST_GRANT2: begin
          if (!hbusreq2 || (tenure_at_max && hbusreq1)) begin
            if (hbusreq1)      state_d = ST_GRANT1;
            else if (hbusreq2) state_d = ST_GRANT2;
            else               state_d = ST_PARK;
          end
        end
        default: state_d = ST_PARK;
      endcase
      // Remember which master just gave up the bus for the next tie break.
      if ((state_d != state_q) && (state_q != ST_PARK)) begin
        last_owner_d = (state_q == ST_GRANT2) ? HM_M2 : HM_M1;
      end
    end
  end

  assign hmaster_d    = state_hm(state_d, PARK_HM);
  assign state_change = (state_d != state_q);

  // Count only completed active beats of a granted owner; restart on any
  // owner change, and flush any stale count while parked.
  assign tenure_inc = hready && htrans && (state_q != ST_PARK);
  assign tenure_clr = state_change || ((state_q == ST_PARK) && (tenure_cnt != '0));

  ahb_tenure_cnt #(
    .MAX_TENURE(MAX_TENURE)
  ) u_tenure (
    .hclk    (hclk),
    .hresetn (hresetn),
    .inc     (tenure_inc),
    .clr     (tenure_clr),
    .count   (tenure_cnt),
    .at_max  (tenure_at_max)
  );

  // State, pointer and registered grant outputs.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q        <= ST_PARK;
      last_owner_q   <= HM_M2;
      hmaster_q      <= PARK_HM;
      hmaster_data_q <= PARK_HM;
      hgrant1_q      <= PARK_HM[0];
      hgrant2_q      <= PARK_HM[1];
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hmaster_q    <= hmaster_d;
      hgrant1_q    <= hmaster_d[0];
      hgrant2_q    <= hmaster_d[1];
      if (hready) begin
        hmaster_data_q <= hmaster_q;
      end
    end
  end

  assign hgrant1      = hgrant1_q;
  assign hgrant2      = hgrant2_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_TENURE, default 16: the number of active address-phase beats after which the owner must yield if the other master is requesting; legal range 2..255.
REQ-002 The module SHALL have parameter PARK_MASTER, default 1: the master granted when nobody requests; legal values 1 or 2.
REQ-003 Port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port hresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port hbusreq1, input, 1 bit: bus request from master 1.
REQ-006 Port hbusreq2, input, 1 bit: bus request from master 2.
REQ-007 Port htrans, input, 1 bit: transfer type of the currently granted master; 1 = active (NONSEQ), 0 = IDLE.
REQ-008 Port hready, input, 1 bit: 1 = current transfer completes this cycle; 0 = slave is extending the transfer.
REQ-009 Port hgrant1, output, 1 bit: grant to master 1; registered.
REQ-010 Port hgrant2, output, 1 bit: grant to master 2; registered.
REQ-011 Port hmaster, output, 2 bits: address-phase owner; 2'b01 = master 1, 2'b10 = master 2.
REQ-012 Port hmaster_data, output, 2 bits: data-phase owner, same encoding; drives the hwdata and hresp return mux.

Function
REQ-013 States SHALL be PARK, GRANT1 and GRANT2; PARK grants PARK_MASTER with hmaster encoded accordingly.
REQ-014 Exactly one of hgrant1 and hgrant2 SHALL be 1 in every cycle, and hmaster SHALL match it.
REQ-015 State, grants and hmaster SHALL change only on an edge where hready=1; with hready=0 all of them hold, whatever the requests or the tenure count.
REQ-016 From PARK with hready=1: one requester moves to that master's GRANT state; both requesting moves to the master not equal to last_owner (round-robin pointer, reset to 2 so master 1 wins first); none requesting stays in PARK.
REQ-017 From GRANTn with hready=1, the arbiter SHALL re-arbitrate when hbusreqn=0, or when tenure == MAX_TENURE and the other master requests.
REQ-018 On re-arbitration the other master is granted if it requests; otherwise GRANTn is kept if hbusreqn=1, else the state moves to PARK.
REQ-019 last_owner SHALL update to the outgoing master on every grant change.
REQ-020 The tenure counter, 8 bits wide, SHALL increment on each cycle with hready=1 and htrans=1 while in a GRANT state, and saturate at MAX_TENURE.
REQ-021 The tenure counter SHALL clear on every grant change and in PARK.
REQ-022 If MAX_TENURE is reached and the other master is not requesting, the owner SHALL keep the bus and the counter SHALL stay saturated.
REQ-023 hmaster_data SHALL load hmaster on every edge with hready=1 and hold otherwise, giving a one-beat lag behind the address phase.
REQ-024 Grant latency: a request seen at edge k with hready=1 and the bus free SHALL be granted at edge k+1.

Reset
REQ-025 On an hclk edge with hresetn=0: state=PARK, hgrant of PARK_MASTER=1, the other hgrant=0, hmaster=hmaster_data=PARK_MASTER encoding, tenure=0, last_owner=2.
REQ-026 Reset SHALL take effect mid-burst and mid-wait-state regardless of hready; the first arbitration SHALL occur on the first hready=1 edge after release.

Structure
REQ-027 Package ahb_arb_pkg SHALL hold the state enum, the hmaster encodings (HM_M1, HM_M2) and the tenure counter width.
REQ-028 Sub-module ahb_tenure_cnt SHALL implement the saturating tenure counter (inputs: inc, clr; output: count and at_max); all other logic stays in ahb_arbiter.

Verification
REQ-029 Scenario: reset, then hbusreq1=1 alone with hready=1 -> hgrant1=1, hmaster=01 one edge later; hmaster_data=01 one further edge later.
REQ-030 Scenario: both requests rise in the same cycle from PARK -> master 1 is granted; master 1 drops its request -> master 2 is granted on the next hready=1 edge.
REQ-031 Scenario: master 1 holds its request with htrans=1 and hready=1 for 20 cycles while master 2 requests -> hgrant2 rises exactly after 16 counted beats.
REQ-032 Scenario: hready=0 for 5 cycles while the owner drops its request -> grants and hmaster frozen; handover occurs on the first hready=1 edge; hmaster_data changes one hready edge later.
REQ-033 Scenario: hresetn=0 for one edge during a master 2 burst -> next cycle hgrant1=1, hgrant2=0, hmaster=01, tenure=0.
REQ-034 Scenario: no requests for 10 cycles -> state PARK, hgrant1=1; a single-grant assertion (exactly one hgrant high) holds in every cycle of every test.
